prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream configuration controller for the FSM instruction/constant memory, which is a serial shift register programmed via a prog_enable/prog_data pair.
- Accepts bytes over a valid/ready handshake and serialises exactly MEM_WIDTH bits, MSB of each byte first.
- Holds the FSM core stalled while programming and flags when the image is complete.
- Sits between the host/SPI byte front-end and the instruction memory.

Parameters:
- MEM_WIDTH, 80, total shift-register bits to program. Default is 2 constants x 16 + 8 states x 6.
- BYTE_WIDTH, 8, width of the input data word.

Ports:
- clock  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a programming session
- abort  input  1  synchronous cancel of an ongoing session
- in_valid  input  1  input byte valid
- in_ready  output  1  loader can accept a byte
- in_data  input  BYTE_WIDTH  input byte
- prog_enable  output  1  shift enable to instruction memory
- prog_data  output  1  serial bit to instruction memory
- fsm_hold  output  1  stalls the FSM core while high
- busy  output  1  session in progress
- done  output  1  one-cycle pulse when the last bit has been shifted
- loaded  output  1  sticky: a complete image is resident

Behaviour:
- Reset values (async on rst=1): state=IDLE, bit_cnt=0, byte_reg=0. All outputs are 0, including loaded.
- State machine, encoded IDLE/LOAD/SHIFT/DONE:
  - IDLE: start=1 -> LOAD. On that transition bit_cnt:=0 and loaded:=0.
  - LOAD: in_ready=1. On in_valid&&in_ready, byte_reg:=in_data and go to SHIFT with beat counter :=0. Otherwise stay in LOAD indefinitely.
  - SHIFT: prog_enable=1, prog_data=byte_reg[BYTE_WIDTH-1]. Each cycle: byte_reg shifts left one (zero fill), bit_cnt+1, beat+1.
    - If bit_cnt==MEM_WIDTH-1 this cycle -> DONE.
    - Else if beat==BYTE_WIDTH-1 -> LOAD.
  - DONE: done=1 and loaded:=1 (set on exit), then IDLE.
- prog_enable and prog_data are decoded only from registered state and byte_reg. No combinational path from inputs to them.
- busy=1 in LOAD, SHIFT and DONE. fsm_hold=busy.
- in_ready=1 only in LOAD, and depends only on state (no combinational path from in_valid).
- Byte rate with in_valid held high: 1 accept cycle + 8 shift cycles = one byte per 9 cycles. Session length = ceil(MEM_WIDTH/BYTE_WIDTH) accepts + MEM_WIDTH shift cycles + 1 DONE cycle.
- Partial final byte: when MEM_WIDTH is not a multiple of BYTE_WIDTH, only the top (MEM_WIDTH mod BYTE_WIDTH) bits of the last byte are shifted. The rest are discarded.
- Bit order: the first bit shifted ends at the memory MSB. The image is therefore sent memory-MSB-first.
- Counters: bit_cnt is $clog2(MEM_WIDTH+1) bits; beat is $clog2(BYTE_WIDTH) bits. bit_cnt never exceeds MEM_WIDTH.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next state is IDLE. loaded stays 0, no done pulse, and prog_enable is low from the next cycle. abort has priority over every other transition, including the DONE exit. abort in IDLE has no effect.
- start and abort asserted together in IDLE: start wins (abort is a no-op in IDLE).
- rst mid-session: immediate return to reset values. The memory contents are the memory's own concern.
- Bytes presented while in_ready=0 are not consumed. The producer must hold them.

Test Plan:
- MEM_WIDTH=16, start, bytes 0xA5 then 0x3C with in_valid held -> prog_data sequence 1010010100111100; prog_enable high 16 cycles; done pulse at cycle 19 after start; loaded=1; fsm_hold low afterwards.
- MEM_WIDTH=12, bytes 0xF0, 0xB7 -> 12 shifts, bits 111100001011; only 2 bytes accepted; in_ready never rises again.
- Default MEM_WIDTH=80, in_valid toggling every other cycle -> exactly 10 accepts, 80 prog_enable cycles, one done pulse; no byte lost or duplicated.
- abort asserted in the 3rd SHIFT cycle of byte 2 -> prog_enable low next cycle; state IDLE; loaded=0; done never asserted; a new start restarts with bit_cnt=0.
- start pulsed again mid-session -> no effect on counts; done after the original 80 bits.
- rst asserted asynchronously mid-SHIFT (between clock edges) -> all outputs 0 immediately; in_ready=0 until the next start.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream loader for the serial instruction/constant memory: takes bytes over
// valid/ready and shifts exactly MEM_WIDTH bits out MSB-first while holding the FSM core.
module prog_loader #(
  parameter int MEM_WIDTH  = 80,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  prog_enable,
  output logic                  prog_data,
  output logic                  fsm_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded
);

  localparam int CNT_W  = $clog2(MEM_WIDTH + 1);
  localparam int BEAT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(MEM_WIDTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BYTE_WIDTH-1:0] byte_q, byte_d;
  logic                  loaded_q, loaded_d;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      beat_q    <= '0;
      byte_q    <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      beat_q    <= beat_d;
      byte_q    <= byte_d;
      loaded_q  <= loaded_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    beat_d    = beat_q;
    byte_d    = byte_q;
    loaded_d  = loaded_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          loaded_d  = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          byte_d  = in_data;
          beat_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        byte_d    = {byte_q[BYTE_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        beat_d    = beat_q + BEAT_W'(1);
        // The bit budget ends the session even mid-byte; leftover low bits are dropped.
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else if (beat_q == LAST_BEAT) begin
          state_d = LOAD;
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A cancelled session must never mark the image resident.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      loaded_d = loaded_q;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign prog_enable = (state_q == SHIFT);
  assign prog_data   = prog_enable & byte_q[BYTE_WIDTH-1];
  assign busy        = (state_q != IDLE);
  assign fsm_hold    = busy;
  assign done        = (state_q == DONE);
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: three instances (MEM_WIDTH 16, 12, 80) checked every cycle
// against a bit-queue model, plus literal expectations for each directed session.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [3];
  logic       start_s [3];
  logic       abort_s [3];
  logic       valid_s [3];
  logic [7:0] data_s  [3];
  logic       rdy_a [3], en_a [3], pd_a [3], hold_a [3], busy_a [3], done_a [3], ld_a [3];

  int         nvec  = 0;
  int         nfail = 0;
  int         en_cnt [3], done_cnt [3], acc_cnt [3];
  logic [79:0] cap [3];
  bit   [7:0] img [3][10];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int MW = (gi == 0) ? 16 : (gi == 1) ? 12 : 80;
    logic rst_l, rdy_l, en_l, pd_l, hold_l, busy_l, done_l, ld_l;
    assign rst_l = rst_s[gi];

    prog_loader #(.MEM_WIDTH(MW), .BYTE_WIDTH(8)) u_dut (
      .clock(clk), .rst(rst_l), .start(start_s[gi]), .abort(abort_s[gi]),
      .in_valid(valid_s[gi]), .in_ready(rdy_l), .in_data(data_s[gi]),
      .prog_enable(en_l), .prog_data(pd_l), .fsm_hold(hold_l), .busy(busy_l),
      .done(done_l), .loaded(ld_l)
    );
    assign rdy_a[gi]  = rdy_l;
    assign en_a[gi]   = en_l;
    assign pd_a[gi]   = pd_l;
    assign hold_a[gi] = hold_l;
    assign busy_a[gi] = busy_l;
    assign done_a[gi] = done_l;
    assign ld_a[gi]   = ld_l;

    // Model: a session is a queue of bits still to shift plus a count of bits already queued.
    bit q[$];
    int pushed, shifted;
    bit act, indone, ldm;

    initial begin
      pushed = 0; shifted = 0; act = 0; indone = 0; ldm = 0;
      forever begin
        @(posedge clk or posedge rst_l);
        if (rst_l) begin
          q.delete(); pushed = 0; shifted = 0; act = 0; indone = 0; ldm = 0;
        end else if (act && abort_s[gi]) begin
          act = 0; indone = 0; q.delete();
        end else if (!act) begin
          if (start_s[gi]) begin
            act = 1; ldm = 0; pushed = 0; shifted = 0;
          end
        end else if (indone) begin
          indone = 0; act = 0; ldm = 1;
        end else if (q.size() > 0) begin
          void'(q.pop_front());
          shifted++;
          if (shifted == MW) indone = 1;
        end else if (valid_s[gi]) begin
          int n;
          n = (MW - pushed < 8) ? MW - pushed : 8;
          for (int j = 0; j < n; j++) q.push_back(data_s[gi][7-j]);
          pushed += n;
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        begin
          bit e_en, e_pd, e_rdy;
          e_en  = (q.size() > 0);
          e_pd  = e_en ? q[0] : 1'b0;
          e_rdy = act && !indone && (q.size() == 0);
          chk($sformatf("u%0d.in_ready", gi), 80'(rdy_l), 80'(e_rdy));
          chk($sformatf("u%0d.prog_enable", gi), 80'(en_l), 80'(e_en));
          chk($sformatf("u%0d.prog_data", gi), 80'(pd_l), 80'(e_pd));
          chk($sformatf("u%0d.busy", gi), 80'(busy_l), 80'(act));
          chk($sformatf("u%0d.fsm_hold", gi), 80'(hold_l), 80'(act));
          chk($sformatf("u%0d.done", gi), 80'(done_l), 80'(indone));
          chk($sformatf("u%0d.loaded", gi), 80'(ld_l), 80'(ldm));
        end
        if (en_l) begin
          en_cnt[gi]++;
          cap[gi] = {cap[gi][78:0], pd_l};
        end
        if (done_l) done_cnt[gi]++;
        if (rdy_l && valid_s[gi]) acc_cnt[gi]++;
      end
    end
  end

  task automatic clear(input int i);
    en_cnt[i] = 0; done_cnt[i] = 0; acc_cnt[i] = 0; cap[i] = '0;
  endtask

  task automatic run_session(input int i, input int nb, input bit tog, input int restart_at,
                             input int abort_at, input bit exp_done, input int maxcyc,
                             output int done_at);
    int  k, cyc;
    bit  acc, seen;
    k = 0; seen = 0; done_at = -1;
    clear(i);
    @(posedge clk); #1; start_s[i] = 1'b1;
    @(posedge clk); #1; start_s[i] = 1'b0;
    for (cyc = 0; cyc < maxcyc && !seen; cyc++) begin
      data_s[i]  = (k < nb) ? img[i][k] : 8'h00;
      valid_s[i] = (k < nb) && (!tog || (cyc % 2 == 0));
      start_s[i] = (cyc == restart_at);
      abort_s[i] = (cyc == abort_at);
      @(negedge clk);
      acc = valid_s[i] && rdy_a[i];
      if (done_a[i]) begin
        seen = 1; done_at = cyc + 1;
      end
      @(posedge clk); #1;
      if (acc) k++;
    end
    valid_s[i] = 1'b0; start_s[i] = 1'b0; abort_s[i] = 1'b0;
    if (exp_done) chk($sformatf("u%0d.session_done", i), 80'(seen), 80'(1));
    $display("session u%0d: accepts=%0d shifts=%0d done_pulses=%0d done_cycle=%0d bits=%0h",
             i, acc_cnt[i], en_cnt[i], done_cnt[i], done_at, cap[i]);
  endtask

  initial begin
    int da;
    img[0][0] = 8'hA5; img[0][1] = 8'h3C;
    img[1][0] = 8'hF0; img[1][1] = 8'hB7; img[1][2] = 8'hFF;
    img[2][0] = 8'h01; img[2][1] = 8'h23; img[2][2] = 8'h45; img[2][3] = 8'h67;
    img[2][4] = 8'h89; img[2][5] = 8'hAB; img[2][6] = 8'hCD; img[2][7] = 8'hEF;
    img[2][8] = 8'h5A; img[2][9] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; abort_s[i] = 1'b0; valid_s[i] = 1'b0;
      data_s[i] = 8'h00;
      clear(i);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.reset_busy", i), 80'(busy_a[i]), 80'(0));
      chk($sformatf("u%0d.reset_ready", i), 80'(rdy_a[i]), 80'(0));
      chk($sformatf("u%0d.reset_loaded", i), 80'(ld_a[i]), 80'(0));
      rst_s[i] = 1'b0;
    end

    // MEM_WIDTH=16: two full bytes, valid held high.
    run_session(0, 2, 1'b0, -1, -1, 1'b1, 60, da);
    chk("u0.bits", cap[0], 80'(16'b1010010100111100));
    chk("u0.shift_cycles", 80'(en_cnt[0]), 80'(16));
    chk("u0.done_pulses", 80'(done_cnt[0]), 80'(1));
    chk("u0.done_cycle", 80'(da), 80'(19));
    chk("u0.loaded_after", 80'(ld_a[0]), 80'(1));
    chk("u0.hold_after", 80'(hold_a[0]), 80'(0));

    // MEM_WIDTH=12: a third byte is offered but must never be taken.
    run_session(1, 3, 1'b0, -1, -1, 1'b1, 60, da);
    chk("u1.bits", cap[1], 80'(12'b111100001011));
    chk("u1.shift_cycles", 80'(en_cnt[1]), 80'(12));
    chk("u1.accepts", 80'(acc_cnt[1]), 80'(2));
    chk("u1.loaded_after", 80'(ld_a[1]), 80'(1));

    // start+abort together in IDLE: start wins; then abort cancels.
    @(posedge clk); #1; start_s[1] = 1'b1; abort_s[1] = 1'b1;
    @(posedge clk); #1; start_s[1] = 1'b0; abort_s[1] = 1'b0;
    @(negedge clk);
    chk("u1.start_over_abort_busy", 80'(busy_a[1]), 80'(1));
    chk("u1.start_clears_loaded", 80'(ld_a[1]), 80'(0));
    @(posedge clk); #1; abort_s[1] = 1'b1;
    @(posedge clk); #1; abort_s[1] = 1'b0;
    @(negedge clk);
    chk("u1.abort_idle_busy", 80'(busy_a[1]), 80'(0));
    chk("u1.abort_loaded", 80'(ld_a[1]), 80'(0));

    // MEM_WIDTH=80: abort in the 3rd shift cycle of byte 2.
    run_session(2, 10, 1'b0, -1, 12, 1'b0, 40, da);
    chk("u2.abort_shift_cycles", 80'(en_cnt[2]), 80'(11));
    chk("u2.abort_bits", cap[2], 80'(11'b00000001001));
    chk("u2.abort_done_pulses", 80'(done_cnt[2]), 80'(0));
    chk("u2.abort_loaded", 80'(ld_a[2]), 80'(0));
    chk("u2.abort_busy", 80'(busy_a[2]), 80'(0));

    // Full 80-bit image with in_valid toggling and a stray start mid-session.
    run_session(2, 10, 1'b1, 30, -1, 1'b1, 400, da);
    chk("u2.bits", cap[2], 80'h0123456789ABCDEF5AC3);
    chk("u2.accepts", 80'(acc_cnt[2]), 80'(10));
    chk("u2.shift_cycles", 80'(en_cnt[2]), 80'(80));
    chk("u2.done_pulses", 80'(done_cnt[2]), 80'(1));
    chk("u2.loaded_after", 80'(ld_a[2]), 80'(1));

    // Asynchronous reset in the middle of a SHIFT phase.
    clear(0);
    @(posedge clk); #1; start_s[0] = 1'b1;
    @(posedge clk); #1; start_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    chk("u0.pre_rst_enable", 80'(en_a[0]), 80'(1));
    #2; rst_s[0] = 1'b1;
    #1;
    chk("u0.rst_enable", 80'(en_a[0]), 80'(0));
    chk("u0.rst_data", 80'(pd_a[0]), 80'(0));
    chk("u0.rst_busy", 80'(busy_a[0]), 80'(0));
    chk("u0.rst_hold", 80'(hold_a[0]), 80'(0));
    chk("u0.rst_loaded", 80'(ld_a[0]), 80'(0));
    @(posedge clk); #1; rst_s[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("u0.ready_after_rst", 80'(rdy_a[0]), 80'(0));
    end
    valid_s[0] = 1'b0;
    $display("session u0: async reset mid-shift, loader idle afterwards");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
